// File: rtl/console_typer_pkg.sv
// Shared types and ASCII constants for the console_typer serial source.
package console_typer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        GAP
    } state_t;

    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_XON  = 8'h11;
    localparam logic [7:0] ASCII_XOFF = 8'h13;

endpackage

// File: rtl/console_typer_if.sv
// Write-side and flow-monitor bus between a loader/debug master and console_typer.
interface console_typer_if;

    logic [7:0] wr_data;
    logic       wr_en;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       flow_valid;
    logic [7:0] flow_data;

    modport master (
        output wr_data, wr_en, flow_valid, flow_data,
        input  full, empty, overflow
    );

    modport slave (
        input  wr_data, wr_en, flow_valid, flow_data,
        output full, empty, overflow
    );

endinterface

// File: rtl/console_typer_byte_fifo.sv
// Synchronous byte FIFO with registered occupancy count and a sticky overflow flag.
module byte_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count,
    output logic             overflow
);

    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    // A write while full is dropped even if a pop frees a slot in the same cycle.
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/console_typer.sv
// FIFO-fed 8N1 serial source with inter-character and post-CR gaps.
// Define CONSOLE_TYPER_XONXOFF_EN to let XOFF/XON bytes on the flow monitor gate new frames.
module console_typer
    import console_typer_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217,
    parameter int FIFO_AW      = 4,
    parameter int CHAR_GAP     = 250,
    parameter int LINE_GAP     = 2500000
) (
    input  logic            clk,
    input  logic            rst_n,
    console_typer_if.slave  bus,
    input  logic            pause,
    output logic            busy,
    output logic            txd
);

    localparam int MAX_A     = (CLKS_PER_BIT > LINE_GAP) ? CLKS_PER_BIT : LINE_GAP;
    localparam int MAX_CNT   = (MAX_A > CHAR_GAP) ? MAX_A : CHAR_GAP;
    localparam int CNT_W     = $clog2(MAX_CNT + 1);
    localparam int CHAR_LAST_I = (CHAR_GAP > 0) ? CHAR_GAP - 1 : 0;
    localparam int LINE_LAST_I = (LINE_GAP > 0) ? LINE_GAP - 1 : 0;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CHAR_LAST = CNT_W'(CHAR_LAST_I);
    localparam logic [CNT_W-1:0] LINE_LAST = CNT_W'(LINE_LAST_I);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       bit_idx, idx_nxt;
    logic [7:0]       shreg, shreg_nxt;
    logic             is_cr, is_cr_nxt;
    logic             txd_nxt;
    logic             pop;
    logic             hold;
    logic [7:0]       fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_overflow;
    logic [FIFO_AW:0] fifo_count_unused;
    logic             gap_zero;
    logic [CNT_W-1:0] gap_last;

    byte_fifo #(
        .WIDTH (8),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_data  (bus.wr_data),
        .wr_en    (bus.wr_en),
        .rd_en    (pop),
        .rd_data  (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count_unused),
        .overflow (fifo_overflow)
    );

    assign bus.full     = fifo_full;
    assign bus.empty    = fifo_empty;
    assign bus.overflow = fifo_overflow;

`ifdef CONSOLE_TYPER_XONXOFF_EN
    logic xoff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xoff <= 1'b0;
        end else if (bus.flow_valid) begin
            if (bus.flow_data == ASCII_XOFF) begin
                xoff <= 1'b1;
            end else if (bus.flow_data == ASCII_XON) begin
                xoff <= 1'b0;
            end
        end
    end

    assign hold = pause | xoff;
`else
    logic unused_flow;
    assign unused_flow = ^{bus.flow_valid, bus.flow_data};
    assign hold        = pause;
`endif

    assign gap_zero = is_cr ? (LINE_GAP == 0) : (CHAR_GAP == 0);
    assign gap_last = is_cr ? LINE_LAST : CHAR_LAST;
    assign busy     = (state != IDLE);

    // txd is registered from the current state, so the line lags the FSM by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            is_cr   <= 1'b0;
            txd     <= 1'b1;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= idx_nxt;
            shreg   <= shreg_nxt;
            is_cr   <= is_cr_nxt;
            txd     <= txd_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = bit_idx;
        shreg_nxt = shreg;
        is_cr_nxt = is_cr;
        txd_nxt   = 1'b1;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && !hold) begin
                    pop       = 1'b1;
                    shreg_nxt = fifo_head;
                    is_cr_nxt = (fifo_head == ASCII_CR);
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                    state_nxt = START;
                end
            end
            START: begin
                txd_nxt = 1'b0;
                if (cnt == BIT_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = DATA;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            DATA: begin
                txd_nxt = shreg[0];
                if (cnt == BIT_LAST) begin
                    cnt_nxt   = '0;
                    shreg_nxt = {1'b0, shreg[7:1]};
                    idx_nxt   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_nxt = STOP;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = gap_zero ? IDLE : GAP;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt == gap_last) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_console_typer.sv
// Randomized self-checking bench for console_typer: a UART receiver model decodes txd
// and compares bytes and frame spacing against a queue of accepted writes.
module tb_console_typer;

    localparam int CPB   = 4;
    localparam int CG    = 3;
    localparam int LG    = 20;
    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;

    logic clk;
    logic rst_n;
    logic pause;
    logic busy;
    logic txd;

    console_typer_if bus_if ();

    console_typer #(
        .CLKS_PER_BIT (CPB),
        .FIFO_AW      (AW),
        .CHAR_GAP     (CG),
        .LINE_GAP     (LG)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if),
        .pause (pause),
        .busy  (busy),
        .txd   (txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_checks = 0;
    int         n_err    = 0;
    logic [7:0] mdl_q[$];
    bit         mdl_ovf  = 1'b0;
    logic [7:0] stim_q[$];
    logic [7:0] rx_bytes[$];
    int         rx_starts[$];
    int         t0;
    int         busy_cnt;

    task automatic checkOutput(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_err++;
            $display("[TB] FAIL %s: got=%0d (0x%0h) expected=%0d (0x%0h) at cycle %0d",
                     tag, got, got, exp, exp, cyc);
        end
    endtask

    function automatic int gapOf(input logic [7:0] b);
        return (b == 8'h0D) ? LG : CG;
    endfunction

    // Receiver model: detects the start bit, then samples mid-bit every CPB cycles.
    bit         rx_active;
    int         rx_cnt;
    int         rx_start;
    logic [7:0] rx_byte;
    initial begin
        rx_active = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rx_active = 1'b0;
            end else if (!rx_active) begin
                if (txd === 1'b0) begin
                    rx_active = 1'b1;
                    rx_cnt    = 0;
                    rx_start  = cyc;
                    rx_byte   = '0;
                end
            end else begin
                rx_cnt++;
                if (rx_cnt == CPB / 2) begin
                    checkOutput("start_bit", int'(txd), 0);
                end else if (rx_cnt < 9 * CPB && ((rx_cnt - CPB / 2) % CPB) == 0) begin
                    rx_byte[(rx_cnt - CPB / 2) / CPB - 1] = txd;
                end else if (rx_cnt == 9 * CPB + CPB / 2) begin
                    checkOutput("stop_bit", int'(txd), 1);
                    rx_bytes.push_back(rx_byte);
                    rx_starts.push_back(rx_start);
                    checkOutput("frame_expected", int'(mdl_q.size() > 0), 1);
                    if (mdl_q.size() > 0) begin
                        checkOutput("rx_byte", int'(rx_byte), int'(mdl_q.pop_front()));
                    end
                    rx_active = 1'b0;
                end
            end
        end
    end

    task automatic checkFlags(input int acc);
        checkOutput("full", int'(bus_if.full), int'(acc == DEPTH));
        checkOutput("empty", int'(bus_if.empty), int'(acc == 0));
        checkOutput("overflow", int'(bus_if.overflow), int'(mdl_ovf));
    endtask

    // Writes stim_q on consecutive cycles; paused_fill models acceptance into a stalled FIFO.
    task automatic applyStimulus(input bit paused_fill);
        int acc = 0;
        foreach (stim_q[i]) begin
            @(negedge clk);
            if (paused_fill && i > 0) checkFlags(acc);
            bus_if.wr_en   = 1'b1;
            bus_if.wr_data = stim_q[i];
            @(posedge clk);
            #1;
            if (i == 0) t0 = cyc;
            if (!paused_fill || acc < DEPTH) begin
                mdl_q.push_back(stim_q[i]);
                acc++;
            end else begin
                mdl_ovf = 1'b1;
            end
        end
        @(negedge clk);
        bus_if.wr_en = 1'b0;
        if (paused_fill) checkFlags(acc);
    endtask

    task automatic waitDrain(input int budget);
        bit done = 1'b0;
        busy_cnt = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (mdl_q.size() == 0 && !busy) begin
                done = 1'b1;
                break;
            end
        end
        checkOutput("drain_done", int'(done), 1);
    endtask

    task automatic checkSpacing(input int base, input int n, input int ref_cyc, input int lat);
        checkOutput("frame_count", rx_bytes.size() - base, n);
        if (rx_bytes.size() - base == n) begin
            checkOutput("first_start", rx_starts[base] - ref_cyc, lat);
            for (int k = 1; k < n; k++) begin
                checkOutput("frame_spacing", rx_starts[base + k] - rx_starts[base + k - 1],
                            10 * CPB + gapOf(rx_bytes[base + k - 1]) + 1);
            end
        end
    endtask

    task automatic flowStrobe(input logic [7:0] b);
        @(negedge clk);
        bus_if.flow_valid = 1'b1;
        bus_if.flow_data  = b;
        @(negedge clk);
        bus_if.flow_valid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int rel;
        int n;
        logic [7:0] b;

        rst_n             = 1'b0;
        pause             = 1'b0;
        bus_if.wr_en      = 1'b0;
        bus_if.wr_data    = '0;
        bus_if.flow_valid = 1'b0;
        bus_if.flow_data  = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_txd", int'(txd), 1);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_full", int'(bus_if.full), 0);
        checkOutput("rst_empty", int'(bus_if.empty), 1);
        checkOutput("rst_overflow", int'(bus_if.overflow), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] single byte 0xA5");
        base   = rx_bytes.size();
        stim_q = '{8'hA5};
        applyStimulus(1'b0);
        waitDrain(500);
        checkSpacing(base, 1, t0, 2);
        checkOutput("busy_cycles", busy_cnt, 10 * CPB + CG);

        $display("[TB] back-to-back A, CR, B");
        base   = rx_bytes.size();
        stim_q = '{8'h41, 8'h0D, 8'h42};
        applyStimulus(1'b0);
        waitDrain(1000);
        checkSpacing(base, 3, t0, 2);

        $display("[TB] paused fill with overflow");
        pause = 1'b1;
        base  = rx_bytes.size();
        stim_q.delete();
        for (int i = 0; i < 5; i++) stim_q.push_back(8'($urandom_range(0, 255)));
        applyStimulus(1'b1);
        repeat (50) @(negedge clk);
        checkOutput("paused_no_tx", rx_bytes.size() - base, 0);
        checkOutput("paused_busy", int'(busy), 0);
        pause = 1'b0;
        rel   = cyc;
        waitDrain(2000);
        checkSpacing(base, DEPTH, rel, 2);
        checkOutput("overflow_sticky", int'(bus_if.overflow), 1);

        $display("[TB] pause raised mid-frame");
        base   = rx_bytes.size();
        stim_q = '{8'h31, 8'h32, 8'h33};
        applyStimulus(1'b0);
        repeat (14) @(negedge clk);
        pause = 1'b1;
        repeat (120) @(negedge clk);
        checkOutput("pause_one_frame", rx_bytes.size() - base, 1);
        checkOutput("pause_busy", int'(busy), 0);
        checkOutput("pause_empty", int'(bus_if.empty), 0);
        checkOutput("pause_txd", int'(txd), 1);
        pause = 1'b0;
        rel   = cyc;
        waitDrain(1000);
        checkSpacing(base + 1, 2, rel, 2);

        $display("[TB] reset during DATA");
        stim_q = '{8'h55, 8'h66};
        applyStimulus(1'b0);
        repeat (12) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_txd", int'(txd), 1);
        checkOutput("arst_empty", int'(bus_if.empty), 1);
        checkOutput("arst_busy", int'(busy), 0);
        checkOutput("arst_full", int'(bus_if.full), 0);
        checkOutput("arst_overflow", int'(bus_if.overflow), 0);
        mdl_q.delete();
        mdl_ovf = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        base  = rx_bytes.size();
        repeat (200) @(negedge clk);
        checkOutput("no_residual", rx_bytes.size() - base, 0);
        checkOutput("post_rst_busy", int'(busy), 0);

        $display("[TB] XOFF before queuing two bytes");
        flowStrobe(8'h13);
        base   = rx_bytes.size();
        stim_q = '{8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
        applyStimulus(1'b0);
        repeat (150) @(negedge clk);
`ifdef CONSOLE_TYPER_XONXOFF_EN
        checkOutput("xoff_hold", rx_bytes.size() - base, 0);
        checkOutput("xoff_txd", int'(txd), 1);
        flowStrobe(8'h11);
        waitDrain(1000);
        checkOutput("xon_frames", rx_bytes.size() - base, 2);
`else
        checkOutput("flow_ignored", rx_bytes.size() - base, 2);
        flowStrobe(8'h11);
        waitDrain(1000);
`endif

        $display("[TB] randomized bursts");
        for (int it = 0; it < 10; it++) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'h11 || b == 8'h13) b = 8'h20;
            flowStrobe(b);
            n = $urandom_range(1, DEPTH);
            stim_q.delete();
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) stim_q.push_back(8'h0D);
                else stim_q.push_back(8'($urandom_range(0, 255)));
            end
            base = rx_bytes.size();
            applyStimulus(1'b0);
            waitDrain(2000);
            checkSpacing(base, n, t0, 2);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
